muldiv_unit: RTL

Multi-cycle RV32M execute unit that serves MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ops issued by the EX stage of the cpu pipeline. It is the responder side of the pipeline's start/busy/done stall handshake. The pipeline holds EX while busy is high and captures result on the done pulse. Multiplication is iterative radix-2^BITS_PER_CYCLE; division is iterative restoring radix-2.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/div_iter_core.sv | 49 ++++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX stage and the multi-cycle RV32M unit.
package cpu_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // EX alu_type code that routes an instruction to muldiv_unit
  localparam logic [3:0] ALU_TYPE_MULDIV = 4'b0101;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StMulIter,
    StDivIter,
    StFixup,
    StDone
  } md_state_e;

endpackage

// File: rtl/div_iter_core.sv
// Restoring radix-2 divider datapath: one quotient bit per step on a remainder:quotient register.
module div_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [2*XLEN-1:0] rq_q, rq_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN:0]     diff;

  always_comb begin
    rq_d  = rq_q;
    dvs_d = dvs_q;
    // Shifted partial remainder needs XLEN+1 bits; a clear top bit means no borrow
    diff  = rq_q[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    if (load) begin
      rq_d  = {{XLEN{1'b0}}, dividend};
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rq_d = {diff[XLEN-1:0], rq_q[XLEN-2:0], 1'b1};
      end else begin
        rq_d = {rq_q[2*XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq_q  <= '0;
      dvs_q <= '0;
    end else begin
      rq_q  <= rq_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = rq_q[XLEN-1:0];
  assign remainder = rq_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: iterative multiplier inline, restoring divider in div_iter_core.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned MulIters = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW     = 6;

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;

  logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic              div_load, div_step;
  logic [XLEN-1:0]   a_abs, b_abs, quo, rem;
  logic [2*XLEN-1:0] partial, prod;
  int unsigned       shamt;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    div_load = 1'b0;
    div_step = 1'b0;

    a_signed = (op_q == MD_MULH) || (op_q == MD_MULHSU) || (op_q == MD_DIV) || (op_q == MD_REM);
    b_signed = (op_q == MD_MULH) || (op_q == MD_DIV) || (op_q == MD_REM);
    a_neg    = a_signed & a_q[XLEN-1];
    b_neg    = b_signed & b_q[XLEN-1];
    a_abs    = a_neg ? -a_q : a_q;
    b_abs    = b_neg ? -b_q : b_q;
    div_zero = op_q[2] && (b_q == '0);
    div_ovf  = ((op_q == MD_DIV) || (op_q == MD_REM)) && (a_q == {1'b1, {(XLEN-1){1'b0}}})
               && (b_q == '1);

    shamt    = 32'(cnt_q) * BITS_PER_CYCLE;
    partial  = {{XLEN{1'b0}}, a_q} *
               {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, b_q[BITS_PER_CYCLE-1:0]};
    prod     = neg_q ? -acc_q : acc_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start && !flush) begin
          state_d = StSetup;
          op_d    = funct3;
          a_d     = rs1;
          b_d     = rs2;
        end
      end
      StSetup: begin
        // a_q/b_q become magnitudes; the divider loads them in the same cycle
        a_d      = a_abs;
        b_d      = b_abs;
        acc_d    = '0;
        cnt_d    = '0;
        div_load = 1'b1;
        neg_d    = (op_q[2] && op_q[1]) ? a_neg : (a_neg ^ b_neg);
        if (div_zero) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = StDone;
        end else if (div_ovf) begin
          result_d = op_q[1] ? '0 : a_q;
          state_d  = StDone;
        end else begin
          state_d = op_q[2] ? StDivIter : StMulIter;
        end
      end
      StMulIter: begin
        acc_d = acc_q + (partial << shamt);
        b_d   = b_q >> BITS_PER_CYCLE;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(MulIters - 1)) state_d = StFixup;
      end
      StDivIter: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) state_d = StFixup;
      end
      StFixup: begin
        if (op_q[2]) begin
          if (op_q[1]) result_d = neg_q ? -rem : rem;
          else         result_d = neg_q ? -quo : quo;
        end else begin
          result_d = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  div_iter_core #(
    .XLEN(XLEN)
  ) u_div_iter_core (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quotient (quo),
    .remainder(rem)
  );

  assign busy   = (state_q == StSetup) || (state_q == StMulIter) ||
                  (state_q == StDivIter) || (state_q == StFixup);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
